// File: rtl/if_fetch_stage_pkg.sv
// Shared ISA encodings and fetch-stage state type for the instruction-fetch slice.
package if_fetch_stage_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_HALT  = 5'h01;
  localparam logic [4:0] OP_LOAD  = 5'h02;
  localparam logic [4:0] OP_STORE = 5'h03;
  localparam logic [4:0] OP_ADD   = 5'h04;
  localparam logic [4:0] OP_ADDI  = 5'h05;
  localparam logic [4:0] OP_SUB   = 5'h06;
  localparam logic [4:0] OP_SUBI  = 5'h07;
  localparam logic [4:0] OP_BZ    = 5'h10;
  localparam logic [4:0] OP_BN    = 5'h11;
  localparam logic [4:0] OP_BNN   = 5'h12;
  localparam logic [4:0] OP_JUMP  = 5'h18;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R7 = 3'd7;

  localparam logic [15:0] NOP_WORD = {OP_NOP, 11'd0};

  typedef enum logic [1:0] {
    IF_IDLE   = 2'b00,
    IF_RUN    = 2'b01,
    IF_HALTED = 2'b10
  } if_state_e;

  function automatic logic [4:0] op_of(input logic [15:0] word);
    return word[15:11];
  endfunction

endpackage

// File: rtl/if_fetch_stage_predecode.sv
// Combinational field extraction for one 16-bit instruction word.
module if_predecode
  import if_fetch_stage_pkg::*;
(
  input  logic [15:0] word,
  output logic [4:0]  op,
  output logic [2:0]  r1,
  output logic [2:0]  r2,
  output logic [2:0]  r3,
  output logic [7:0]  imm8,
  output logic        is_jump,
  output logic        is_halt
);

  assign op      = op_of(word);
  assign r1      = word[10:8];
  assign r2      = word[6:4];
  assign r3      = word[2:0];
  assign imm8    = word[7:0];
  assign is_jump = (op == OP_JUMP);
  assign is_halt = (op == OP_HALT);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives IM address, fills the IF/ID register
// and resolves JUMP/HALT locally so a JUMP costs no bubble.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  i_addr,
  input  logic [INSTR_W-1:0] i_data,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic [4:0]         id_op,
  output logic [2:0]         id_r1,
  output logic [2:0]         id_r2,
  output logic [2:0]         id_r3,
  output logic [7:0]         id_imm8,
  output logic               halted
);

  localparam logic [INSTR_W-1:0] NOP_I = INSTR_W'(NOP_WORD);

  if_state_e           state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, id_pc_n;
  logic [INSTR_W-1:0]  instr_n;
  logic                valid_n;

  logic [4:0] f_op;
  logic [2:0] f_r1, f_r2, f_r3;
  logic [7:0] f_imm8;
  logic       f_jump, f_halt;
  logic       d_jump, d_halt;

  // Fetch-side decode steers next PC from the word currently on the IM bus.
  if_predecode u_pd_fetch (
    .word(i_data), .op(f_op), .r1(f_r1), .r2(f_r2), .r3(f_r3),
    .imm8(f_imm8), .is_jump(f_jump), .is_halt(f_halt)
  );

  if_predecode u_pd_id (
    .word(id_instr), .op(id_op), .r1(id_r1), .r2(id_r2), .r3(id_r3),
    .imm8(id_imm8), .is_jump(d_jump), .is_halt(d_halt)
  );

  logic unused_fields;
  assign unused_fields = ^{f_op, f_r1, f_r2, f_r3, d_jump, d_halt};

  assign i_addr = pc;
  assign halted = (state == IF_HALTED);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = id_instr;
    id_pc_n = id_pc;
    valid_n = id_valid;
    case (state)
      IF_IDLE: begin
        valid_n = 1'b0;
        if (start) begin
          state_n = IF_RUN;
          pc_n    = start_pc;
        end
      end
      IF_RUN: begin
        if (branch_taken) begin
          pc_n    = branch_addr;
          instr_n = NOP_I;
          valid_n = 1'b0;
        end else if (!stall) begin
          instr_n = i_data;
          id_pc_n = pc;
          valid_n = 1'b1;
          if (f_jump)      pc_n = ADDR_W'(f_imm8);
          else if (f_halt) state_n = IF_HALTED;
          else             pc_n = pc + ADDR_W'(1);
        end
      end
      IF_HALTED: begin
        instr_n = NOP_I;
        valid_n = 1'b0;
        if (branch_taken) begin
          state_n = IF_RUN;
          pc_n    = branch_addr;
        end
      end
      default: state_n = IF_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IF_IDLE;
      pc       <= RESET_PC;
      id_instr <= NOP_I;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (enable) begin
      state    <= state_n;
      pc       <= pc_n;
      id_instr <= instr_n;
      id_pc    <= id_pc_n;
      id_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage with a behavioural instruction memory.
module tb_if_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'h00;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_addr = 8'h00;
  logic [7:0]  i_addr;
  logic [15:0] i_data;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic [4:0]  id_op;
  logic [2:0]  id_r1, id_r2, id_r3;
  logic [7:0]  id_imm8;
  logic        halted;

  int total = 0;
  int bad = 0;

  if_fetch_stage dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .start_pc(start_pc),
    .stall(stall), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .i_addr(i_addr), .i_data(i_data), .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid), .id_op(id_op), .id_r1(id_r1), .id_r2(id_r2), .id_r3(id_r3),
    .id_imm8(id_imm8), .halted(halted)
  );

  always #5 clock = ~clock;

  // IM image: JUMP->2 at 8, HALT at 23, NOP at FF, LOADs elsewhere.
  function automatic logic [15:0] word_at(input logic [7:0] a);
    if (a == 8'd8)       return {5'h18, 3'b101, 8'h02};
    else if (a == 8'd23) return {5'h01, 11'd0};
    else if (a == 8'hFF) return 16'h0000;
    else                 return {5'h02, a[2:0], a};
  endfunction

  always_comb i_data = word_at(i_addr);

  typedef struct {
    logic       en, st, stl, br;
    logic [7:0] sp, ba;
    logic [7:0] ea;
    logic       ev;
    logic [7:0] epc;
    logic       eh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, st, stl, br, input logic [7:0] sp, ba,
                              input logic [7:0] ea, input logic ev, input logic [7:0] epc,
                              input logic eh);
    vec_t v;
    v.en = en; v.st = st; v.stl = stl; v.br = br; v.sp = sp; v.ba = ba;
    v.ea = ea; v.ev = ev; v.epc = epc; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input logic [7:0] ea, input logic ev, input logic [7:0] epc,
                           input logic eh);
    logic [15:0] w;
    check("i_addr", 16'(i_addr), 16'(ea));
    check("id_valid", 16'(id_valid), 16'(ev));
    check("halted", 16'(halted), 16'(eh));
    if (ev) begin
      w = word_at(epc);
      check("id_pc", 16'(id_pc), 16'(epc));
      check("id_instr", id_instr, w);
      check("id_op", 16'(id_op), 16'(w[15:11]));
      check("id_r1", 16'(id_r1), 16'(w[10:8]));
      check("id_r2", 16'(id_r2), 16'(w[6:4]));
      check("id_r3", 16'(id_r3), 16'(w[2:0]));
      check("id_imm8", 16'(id_imm8), 16'(w[7:0]));
    end else begin
      check("id_instr_nop", id_instr, 16'h0000);
    end
  endtask

  task automatic apply(input vec_t v);
    enable = v.en; start = v.st; stall = v.stl; branch_taken = v.br;
    start_pc = v.sp; branch_addr = v.ba;
    @(posedge clock);
    #1;
    check_out(v.ea, v.ev, v.epc, v.eh);
  endtask

  initial begin
    // Idle ignores branch; start at 0; sequential up to the JUMP at 8.
    vecs.push_back(mk(1,0,0,1, 8'h00, 8'h55, 8'd0, 0, 8'd0, 0));
    vecs.push_back(mk(1,1,0,0, 8'h00, 8'h00, 8'd0, 0, 8'd0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1,0,0,0, 8'h00, 8'h00, 8'(i), 1, 8'(i-1), 0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd2,  1, 8'd8,  0));  // JUMP, no bubble
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd3,  1, 8'd2,  0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd4,  1, 8'd3,  0));
    vecs.push_back(mk(1,0,1,0, 0, 0, 8'd4,  1, 8'd3,  0));  // stall x2
    vecs.push_back(mk(1,0,1,0, 0, 0, 8'd4,  1, 8'd3,  0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd5,  1, 8'd4,  0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd6,  1, 8'd5,  0));
    vecs.push_back(mk(1,0,1,1, 0, 8'd9, 8'd9, 0, 8'd0, 0)); // branch beats stall
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd10, 1, 8'd9,  0));
    vecs.push_back(mk(1,0,0,1, 0, 8'd23, 8'd23, 0, 8'd0, 0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd23, 1, 8'd23, 1));  // single valid HALT
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd23, 0, 8'd0,  1));
    vecs.push_back(mk(1,1,1,0, 8'h40, 0, 8'd23, 0, 8'd0, 1));
    vecs.push_back(mk(1,0,0,1, 0, 8'd12, 8'd12, 0, 8'd0, 0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd13, 1, 8'd12, 0));
    vecs.push_back(mk(0,0,0,1, 0, 8'h30, 8'd13, 1, 8'd12, 0)); // enable=0 freezes
    vecs.push_back(mk(0,0,0,0, 0, 0, 8'd13, 1, 8'd12, 0));
    vecs.push_back(mk(1,0,0,0, 0, 0, 8'd14, 1, 8'd13, 0));

    #2;
    check_out(8'd0, 0, 8'd0, 0);
    check("id_pc_rst", 16'(id_pc), 16'h0000);
    check("id_op_rst", 16'(id_op), 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    check_out(8'd0, 0, 8'd0, 0);
    check("id_pc_midrst", 16'(id_pc), 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // PC wrap from FF to 00.
    apply(mk(1,1,0,0, 8'hFF, 0, 8'hFF, 0, 8'd0, 0));
    apply(mk(1,0,0,0, 0, 0, 8'h00, 1, 8'hFF, 0));
    apply(mk(1,0,0,0, 0, 0, 8'h01, 1, 8'h00, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
